// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller between a debug host and a small CPU core.
// Sequences the CPU reset, gates the CPU clock enable and keeps cycle/instruction counters.
module cpu_run_ctrl #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_start,
  input  logic                 host_step,
  input  logic                 host_stop,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [CNT_WIDTH-1:0] cycle_limit,
  input  logic [PC_WIDTH-1:0]  cpu_pc,
  input  logic                 cpu_fetch,
  input  logic                 cpu_halt,
  input  logic                 cpu_error,
  output logic                 cpu_rst,
  output logic                 cpu_en,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 done,
  output logic                 fault,
  output logic                 bp_hit,
  output logic [1:0]           fault_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CPURST = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic                 r_mode_run;
  logic                 r_rst_second;
  logic                 r_fetch_d;
  logic                 r_bp_mask;
  logic                 r_step_first;
  logic                 r_cpu_en;
  logic                 r_bp_hit;
  logic [1:0]           r_fault_code;
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_instr_cnt;

  logic w_active;
  logic w_fetch_rise;
  logic w_timeout;
  logic w_bp;
  logic w_enter_rst;
  logic w_resume;

  assign w_active     = (r_state == S_RUN) || (r_state == S_STEP);
  // r_fetch_d only tracks fetch while the CPU is enabled, so a frozen FETCH is not re-detected.
  assign w_fetch_rise = w_active && cpu_fetch && !r_fetch_d;
  assign w_timeout    = w_active && (cycle_limit != '0) &&
                        (r_cycle_cnt == cycle_limit - CNT_WIDTH'(1));
  assign w_bp         = w_fetch_rise && bp_en && (cpu_pc == bp_addr) && !r_bp_mask;
  assign w_enter_rst  = (w_next_state == S_CPURST) && (r_state != S_CPURST);
  assign w_resume     = (r_state == S_PAUSE) &&
                        ((w_next_state == S_RUN) || (w_next_state == S_STEP));

  // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (host_start || host_step) w_next_state = S_CPURST;
      S_CPURST: if (r_rst_second) w_next_state = r_mode_run ? S_RUN : S_PAUSE;
      S_RUN: begin
        if (cpu_error)      w_next_state = S_FAULT;
        else if (cpu_halt)  w_next_state = S_DONE;
        else if (host_stop) w_next_state = S_PAUSE;
        else if (w_bp)      w_next_state = S_PAUSE;
        else if (w_timeout) w_next_state = S_FAULT;
      end
      S_STEP: begin
        if (cpu_error)                          w_next_state = S_FAULT;
        else if (cpu_halt)                      w_next_state = S_DONE;
        else if (w_fetch_rise && !r_step_first) w_next_state = S_PAUSE;
        else if (w_timeout)                     w_next_state = S_FAULT;
      end
      S_PAUSE: begin
        if (host_stop)       w_next_state = S_IDLE;
        else if (host_start) w_next_state = S_RUN;
        else if (host_step)  w_next_state = S_STEP;
      end
      S_DONE, S_FAULT: if (host_start) w_next_state = S_CPURST;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-low: it is only seen at a clk edge, and all
  // clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mode_run   <= 1'b0;
      r_rst_second <= 1'b0;
      r_fetch_d    <= 1'b0;
      r_bp_mask    <= 1'b0;
      r_step_first <= 1'b0;
      r_cpu_en     <= 1'b0;
      r_bp_hit     <= 1'b0;
      r_fault_code <= 2'd0;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cpu_en     <= (w_next_state == S_RUN) || (w_next_state == S_STEP);
      r_rst_second <= (r_state == S_CPURST) && !r_rst_second;
      r_step_first <= (r_state == S_PAUSE);
      if (w_enter_rst) begin
        r_mode_run   <= (r_state != S_IDLE) || host_start;
        r_cycle_cnt  <= '0;
        r_instr_cnt  <= '0;
        r_bp_hit     <= 1'b0;
        r_fault_code <= 2'd0;
        r_fetch_d    <= 1'b0;
        r_bp_mask    <= 1'b0;
      end else begin
        if (w_active) begin
          r_fetch_d <= cpu_fetch;
          // The cycle counter parks at cycle_limit-1 when the timeout fires.
          if (!w_timeout && !(&r_cycle_cnt)) r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
          if (w_fetch_rise && !(&r_instr_cnt)) r_instr_cnt <= r_instr_cnt + CNT_WIDTH'(1);
        end
        if (w_resume)          r_bp_mask <= 1'b1;
        else if (w_fetch_rise) r_bp_mask <= 1'b0;
        if ((r_state == S_RUN) && !cpu_error && !cpu_halt && !host_stop && w_bp)
          r_bp_hit <= 1'b1;
        if ((w_next_state == S_FAULT) && (r_state != S_FAULT))
          r_fault_code <= cpu_error ? 2'd1 : 2'd2;
      end
    end
  end

  assign cpu_rst     = (r_state == S_IDLE) || (r_state == S_CPURST);
  assign cpu_en      = r_cpu_en;
  assign state       = r_state;
  assign cycle_count = r_cycle_cnt;
  assign instr_count = r_instr_cnt;
  assign done        = (r_state == S_DONE);
  assign fault       = (r_state == S_FAULT);
  assign bp_hit      = r_bp_hit;
  assign fault_code  = r_fault_code;

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, the CPU program counter width.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, the cycle and instruction counter width.
REQ-003 The block SHALL have clk, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have reset, input, 1 bit, a synchronous active-low reset; the clock is clk.
REQ-005 The block SHALL have host_start, input, 1 bit: start a run, or resume from PAUSE.
REQ-006 The block SHALL have host_step, input, 1 bit: single-step one instruction.
REQ-007 The block SHALL have host_stop, input, 1 bit: pause a run, or abort to IDLE from PAUSE.
REQ-008 The block SHALL have bp_en, input, 1 bit, the breakpoint enable.
REQ-009 The block SHALL have bp_addr, input, PC_WIDTH bits, the breakpoint address.
REQ-010 The block SHALL have cycle_limit, input, CNT_WIDTH bits, the timeout in cycles; 0 disables the timeout.
REQ-011 The block SHALL have cpu_pc, input, PC_WIDTH bits, the CPU program counter.
REQ-012 The block SHALL have cpu_fetch, input, 1 bit, high while the CPU is in its FETCH state.
REQ-013 The block SHALL have cpu_halt and cpu_error, inputs, 1 bit each, the CPU status.
REQ-014 The block SHALL have cpu_rst, output, 1 bit, an active-high reset to the CPU.
REQ-015 The block SHALL have cpu_en, output, 1 bit, a registered CPU clock enable.
REQ-016 The block SHALL have state, output, 3 bits, encoded IDLE=0, CPURST=1, RUN=2, STEP=3, PAUSE=4, DONE=5, FAULT=6.
REQ-017 The block SHALL have cycle_count and instr_count, outputs, CNT_WIDTH bits each.
REQ-018 The block SHALL have done, fault and bp_hit, outputs, 1 bit each.
REQ-019 The block SHALL have fault_code, output, 2 bits: 0=none, 1=cpu_error, 2=timeout.

Function
REQ-020 cpu_rst SHALL be 1 in IDLE and CPURST, and 0 in all other states.
REQ-021 cpu_en SHALL be 1 only in RUN and STEP.
REQ-022 IDLE: host_start -> CPURST with mode=RUN; otherwise host_step -> CPURST with mode=PAUSE; host_start SHALL win when both are high.
REQ-023 CPURST SHALL last exactly 2 cycles, clear both counters and bp_hit, then go to RUN or PAUSE per the stored mode.
REQ-024 RUN and STEP: cycle_count SHALL increment every cycle; instr_count SHALL increment on each cpu_fetch rising edge; both SHALL saturate at all-ones.
REQ-025 RUN exit priority SHALL be: cpu_error -> FAULT (code 1); cpu_halt -> DONE; host_stop -> PAUSE; breakpoint -> PAUSE with bp_hit=1; timeout -> FAULT (code 2).
REQ-026 A breakpoint SHALL be a cpu_fetch rising edge with bp_en=1 and cpu_pc==bp_addr; the CPU completes that cycle, and cpu_en SHALL be 0 from the next cycle.
REQ-027 Timeout SHALL fire when cycle_limit!=0 and cycle_count==cycle_limit-1 in RUN or STEP.
REQ-028 PAUSE: host_start -> RUN; host_step -> STEP; host_stop -> IDLE; priority SHALL be stop > start > step.
REQ-029 The first fetch after leaving PAUSE SHALL NOT trigger a breakpoint, so a run or step can resume past bp_addr.
REQ-030 STEP SHALL return to PAUSE on the first cpu_fetch rising edge occurring on or after the second STEP cycle.
REQ-031 In STEP, cpu_error and cpu_halt SHALL take the RUN exit paths; host_stop SHALL be ignored.
REQ-032 DONE and FAULT SHALL hold until host_start, which goes to CPURST with mode=RUN; counters and fault_code SHALL remain readable until then.
REQ-033 done SHALL be 1 only in DONE, and fault SHALL be 1 only in FAULT; fault_code SHALL clear on entry to CPURST.
REQ-034 Host inputs SHALL be level-sampled each cycle; the block SHALL NOT perform edge detection on host inputs.

Reset
REQ-035 With reset=0 at a clk edge, the block SHALL enter IDLE with cpu_rst=1, cpu_en=0, counters=0, done=0, fault=0, bp_hit=0, fault_code=0.
REQ-036 Reset asserted in any state, including mid-RUN or mid-STEP, SHALL take effect at the next edge and override all other inputs.

Verification
REQ-037 host_start pulse in IDLE -> cpu_rst high 3 cycles (IDLE plus 2 CPURST), then RUN with cpu_en=1; cpu_halt after 40 cycles -> DONE, done=1, cycle_count=40.
REQ-038 bp_en=1, bp_addr=3 -> PAUSE after the fetch at pc=3 with bp_hit=1; host_start -> runs past pc=3 without re-triggering.
REQ-039 From PAUSE, three host_step pulses -> instr_count increases by exactly 3, returning to PAUSE each time.
REQ-040 cycle_limit=25 with no halt -> FAULT, fault_code=2, cycle_count=24; cycle_limit=0 -> no timeout.
REQ-041 cpu_error and cpu_halt high in the same RUN cycle -> FAULT, fault_code=1, done=0.
REQ-042 reset=0 mid-STEP -> next cycle IDLE, cpu_en=0, counters=0.
